// File: rtl/prog_delay_pkg.sv
// Shared helpers for the programmable delay line: constant log2, delay clamping and
// ring-buffer address arithmetic.
package prog_delay_pkg;

  // Constant-function log2 (ceiling) for sizing pointers and the delay port.
  function automatic int unsigned dly_clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  // Requested delay of 0 means 1; anything past the buffer depth saturates.
  function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned max_d);
    if (req == 0) return 1;
    if (req > max_d) return max_d;
    return req;
  endfunction

  // (a - b) mod m for a, b < m, without a divider.
  function automatic int unsigned ring_sub(input int unsigned a, input int unsigned b,
                                           input int unsigned m);
    if (a >= b) return a - b;
    return a + m - b;
  endfunction

endpackage

// File: rtl/prog_delay_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read, no reset on storage.
module prog_delay_sdp_ram import prog_delay_pkg::*; #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = dly_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/prog_delay.sv
// Runtime-programmable delay line over a circular RAM, with clock enable, valid tracking
// and a refill guard so stale buffer contents are never reported valid.
module prog_delay import prog_delay_pkg::*; #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned MAX_DELAY     = 16,
  parameter int unsigned DEFAULT_DELAY = 4,
  parameter int unsigned DW            = dly_clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic [DW-1:0]    delay,
  input  logic             delay_load,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy
);

  localparam int unsigned AW = dly_clog2(MAX_DELAY);

  logic [AW-1:0]    wp_q, wp_d, raddr;
  logic [DW-1:0]    d_q, d_eff;
  logic [DW-1:0]    fill_q, fill_d;
  logic             busy_q;
  logic [WIDTH:0]   bypass_q;
  logic             sel_bypass_q;
  logic [WIDTH:0]   ram_q;

  // A load applies to its own edge, so the read and qualification use the new delay at once.
  always_comb begin
    d_eff = d_q;
    if (delay_load) d_eff = DW'(clamp_delay(32'(delay), MAX_DELAY));
  end

  always_comb begin
    wp_d = wp_q;
    if (en) wp_d = (wp_q == AW'(MAX_DELAY - 1)) ? '0 : wp_q + 1'b1;
  end

  always_comb begin
    fill_d = fill_q;
    if (delay_load) begin
      fill_d = DW'(en);
    end else if (en && (fill_q != DW'(MAX_DELAY))) begin
      fill_d = fill_q + 1'b1;
    end
  end

  assign raddr = AW'(ring_sub(32'(wp_q), 32'(d_eff) - 32'd1, MAX_DELAY));

  prog_delay_sdp_ram #(
    .WIDTH (WIDTH + 1),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (en),
    .waddr (wp_q),
    .wdata ({in_valid, in_data}),
    .re    (en),
    .raddr (raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      fill_q <= '0;
      d_q    <= DW'(DEFAULT_DELAY);
      busy_q <= 1'b1;
    end else begin
      wp_q   <= wp_d;
      fill_q <= fill_d;
      d_q    <= d_eff;
      busy_q <= (fill_d < d_eff);
    end
  end

  // D=1 reads the word written on the same edge, which the RAM cannot return yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bypass_q     <= '0;
      sel_bypass_q <= 1'b1;
    end else if (en) begin
      bypass_q     <= {in_valid, in_data};
      sel_bypass_q <= (d_eff == DW'(1));
    end
  end

  assign out_data  = sel_bypass_q ? bypass_q[WIDTH-1:0] : ram_q[WIDTH-1:0];
  assign out_valid = !busy_q && (sel_bypass_q ? bypass_q[WIDTH] : ram_q[WIDTH]);
  assign busy      = busy_q;

endmodule
